// File: rtl/switch_word_loader_pkg.sv
// Shared types and constants for the switch word loader: FSM encoding,
// lane geometry and a lane-insert helper.
package switch_word_loader_pkg;

    localparam int LANE_W   = 8;
    localparam int LANE_CNT = 4;
    localparam int IDX_W    = $clog2(LANE_CNT);
    localparam int WORD_W   = LANE_W * LANE_CNT;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx,
        input logic [LANE_W-1:0] lane
    );
        logic [WORD_W-1:0] r;
        r = word;
        r[LANE_W*idx +: LANE_W] = lane;
        return r;
    endfunction

endpackage

// File: rtl/switch_word_loader_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on an accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic             armed_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             accept;

    assign differ = (sync2_q != level_q);
    assign accept = differ && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};

            if (!differ || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                level_q <= sync2_q;
            end

            // A button held through reset must be seen released before it may
            // produce a press; fill_q waits until the synchronizer carries real data.
            if (fill_q[1] && !sync2_q && !level_q) begin
                armed_q <= 1'b1;
            end

            press_q <= accept && sync2_q && armed_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/switch_word_loader.sv
// Assembles a 32-bit word from four debounced switch-byte loads and holds it
// for a valid/ready consumer; a clear button discards everything.
module switch_word_loader
    import switch_word_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANE_W-1:0] sw,
    input  logic              btn_load,
    input  logic              btn_clr,
    input  logic              dout_ready,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              busy
);

    logic              load_level;
    logic              load_press;
    logic              clr_level;
    logic              clr_press;
    logic              load_evt;
    logic              clr_evt;

    state_t            state_q;
    logic [WORD_W-1:0] dout_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_load),
        .level   (load_level),
        .press   (load_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clr),
        .level   (clr_level),
        .press   (clr_press)
    );

    // The press pulse coincides with the debounced level going high.
    assign load_evt = load_press && load_level;
    assign clr_evt  = clr_press && clr_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (clr_evt) begin
            state_q <= ST_COLLECT;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (load_evt) begin
                        dout_q <= lane_insert(dout_q, idx_q, sw);
                        idx_q  <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(LANE_CNT - 1)) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (valid_q && dout_ready) begin
                        state_q <= ST_COLLECT;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_COLLECT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign byte_idx   = idx_q;
    assign busy       = (idx_q != '0) || valid_q;

endmodule

// File: tb/tb_switch_word_loader.sv
// Directed bench for switch_word_loader with a scoreboard of expected
// output records popped whenever the DUT outputs change.
module tb_switch_word_loader;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        btn_load;
    logic        btn_clr;
    logic        dout_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic [1:0]  byte_idx;
    logic        busy;

    always #5 clk = ~clk;

    switch_word_loader #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_clr    (btn_clr),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .byte_idx   (byte_idx),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  i;
        logic        v;
    } rec_t;

    rec_t exp_q[$];
    rec_t prev_rec;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   lat;

    function automatic rec_t mk(input logic [31:0] d, input logic [1:0] i, input logic v);
        rec_t r;
        r.d = d;
        r.i = i;
        r.v = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout observed=%0d pending expected=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic load_byte(input logic [7:0] b, input rec_t e, output int cycles);
        sw = b;
        exp_q.push_back(e);
        btn_load = 1'b1;
        wait_drain(cycles);
        btn_load = 1'b0;
        repeat (N + 6) @(negedge clk);
    endtask

    // Scoreboard monitor: every output change must match the next expected record.
    always @(posedge clk) begin
        rec_t cur;
        rec_t e;
        #1;
        if (mon_en) begin
            cur = mk(dout, byte_idx, dout_valid);
            if (cur !== prev_rec) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_change observed=0x%0h/%0d/%0b expected=no change",
                           dout, byte_idx, dout_valid);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (cur === e) else begin
                        failures++;
                        $error("FAIL sb_record observed=0x%0h/%0d/%0b expected=0x%0h/%0d/%0b",
                               cur.d, cur.i, cur.v, e.d, e.i, e.v);
                    end
                    checks++;
                    assert (busy === ((e.i != 2'd0) || e.v)) else begin
                        failures++;
                        $error("FAIL sb_busy observed=%0b expected=%0b", busy, (e.i != 2'd0) || e.v);
                    end
                end
                prev_rec = cur;
            end
        end
    end

    initial begin
        rst = 1'b1;
        sw = 8'h00;
        btn_load = 1'b0;
        btn_clr = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 32'h0);
        chk("reset_valid", {31'd0, dout_valid}, 32'd0);
        chk("reset_idx", {30'd0, byte_idx}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        prev_rec = mk(dout, byte_idx, dout_valid);
        mon_en = 1'b1;
        repeat (N + 4) @(negedge clk);

        // Four loads assemble the word
        load_byte(8'h11, mk(32'h0000_0011, 2'd1, 1'b0), lat);
        checks++;
        assert (lat >= 7 && lat <= 9) else begin
            failures++;
            $error("FAIL press_latency observed=%0d expected=7..9", lat);
        end
        load_byte(8'h22, mk(32'h0000_2211, 2'd2, 1'b0), lat);
        load_byte(8'h33, mk(32'h0033_2211, 2'd3, 1'b0), lat);
        load_byte(8'h44, mk(32'h4433_2211, 2'd0, 1'b1), lat);
        chk("full_dout", dout, 32'h4433_2211);
        chk("full_valid", {31'd0, dout_valid}, 32'd1);
        chk("full_busy", {31'd0, busy}, 32'd1);

        // Load press in HOLD is ignored
        sw = 8'hFF;
        btn_load = 1'b1;
        repeat (20) @(negedge clk);
        btn_load = 1'b0;
        repeat (N + 6) @(negedge clk);
        chk("hold_dout", dout, 32'h4433_2211);
        chk("hold_valid", {31'd0, dout_valid}, 32'd1);

        // Handshake drops valid one cycle later, dout retained
        exp_q.push_back(mk(32'h4433_2211, 2'd0, 1'b0));
        dout_ready = 1'b1;
        wait_drain(lat);
        chk("valid_fall_latency", lat, 32'd1);
        dout_ready = 1'b0;
        chk("post_hs_dout", dout, 32'h4433_2211);

        // Fresh load overwrites lane 0 only
        load_byte(8'hAA, mk(32'h4433_22AA, 2'd1, 1'b0), lat);
        chk("reload_dout", dout, 32'h4433_22AA);
        chk("reload_idx", {30'd0, byte_idx}, 32'd1);

        // Bouncing button writes exactly one byte
        sw = 8'hBB;
        exp_q.push_back(mk(32'h4433_BBAA, 2'd2, 1'b0));
        for (int k = 0; k < 10; k++) begin
            btn_load = ~btn_load;
            repeat (2) @(negedge clk);
        end
        btn_load = 1'b1;
        wait_drain(lat);
        btn_load = 1'b0;
        repeat (N + 10) @(negedge clk);
        chk("bounce_idx", {30'd0, byte_idx}, 32'd2);

        // Clear alone, then two loads, then clear coincident with load
        exp_q.push_back(mk(32'h0, 2'd0, 1'b0));
        btn_clr = 1'b1;
        wait_drain(lat);
        btn_clr = 1'b0;
        repeat (N + 6) @(negedge clk);
        load_byte(8'h55, mk(32'h0000_0055, 2'd1, 1'b0), lat);
        load_byte(8'h66, mk(32'h0000_6655, 2'd2, 1'b0), lat);
        sw = 8'h77;
        exp_q.push_back(mk(32'h0, 2'd0, 1'b0));
        btn_load = 1'b1;
        btn_clr = 1'b1;
        wait_drain(lat);
        btn_load = 1'b0;
        btn_clr = 1'b0;
        repeat (N + 6) @(negedge clk);
        chk("clr_dout", dout, 32'h0);
        chk("clr_idx", {30'd0, byte_idx}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);

        // Reset in HOLD with load held: no press until release and re-press
        load_byte(8'h01, mk(32'h0000_0001, 2'd1, 1'b0), lat);
        load_byte(8'h02, mk(32'h0000_0201, 2'd2, 1'b0), lat);
        load_byte(8'h03, mk(32'h0003_0201, 2'd3, 1'b0), lat);
        load_byte(8'h04, mk(32'h0403_0201, 2'd0, 1'b1), lat);
        sw = 8'h5A;
        btn_load = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(32'h0, 2'd0, 1'b0));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_hold_dout", dout, 32'h0);
        chk("rst_hold_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_hold_idx", {30'd0, byte_idx}, 32'd0);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold_pending", exp_q.size(), 32'd0);
        btn_load = 1'b0;
        repeat (N + 6) @(negedge clk);
        load_byte(8'h99, mk(32'h0000_0099, 2'd1, 1'b0), lat);
        chk("repress_dout", dout, 32'h0000_0099);

        chk("final_pending", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
